// File: rtl/weighted_bitsum_pipe.sv
// weighted_bitsum_pipe: pipelined weighted popcount with threshold compare
// and valid/ready flow control for the WOS rank path.
module weighted_bitsum_pipe #(
  parameter int N = 9,
  parameter int W_BITS = 3,
  parameter int WEIGHTED = 1,
  parameter int PIPE_EVERY = 2,
  localparam int SUM_W = (WEIGHTED != 0)
    ? $clog2(N*((2**W_BITS)-1)+1)
    : $clog2(N+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_bits,
  input  logic [N*W_BITS-1:0] weights,
  input  logic [SUM_W-1:0] threshold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum,
  output logic             ge
);

  localparam int D = $clog2(N);
  localparam int WMAX = (WEIGHTED != 0) ? (2**W_BITS)-1 : 1;

  function automatic int f_cnt(input int l);
    return (N + (1 << l) - 1) >> l;
  endfunction

  function automatic int f_lw(input int l);
    int k;
    k = 1 << l;
    if (k > N) k = N;
    return $clog2(k*WMAX + 1);
  endfunction

  logic w_stall;
  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;

  for (genvar l = 0; l <= D; l++) begin : g_lv
    localparam int C  = f_cnt(l);
    localparam int LW = f_lw(l);
    logic [LW-1:0]    w_q [C];
    logic             w_v;
    logic [SUM_W-1:0] w_t;

    if (l == 0) begin : g_in
      logic [LW-1:0]    w_p [C];
      logic [LW-1:0]    r_p [C];
      logic             r_v;
      logic [SUM_W-1:0] r_t;

      for (genvar i = 0; i < C; i++) begin : g_pr
        if (WEIGHTED != 0) begin : g_w
          assign w_p[i] = in_bits[i] ?
            weights[i*W_BITS +: W_BITS] : '0;
        end else begin : g_b
          assign w_p[i] = in_bits[i];
        end
      end

      if (WEIGHTED == 0) begin : g_nw
        logic w_unused;
        assign w_unused = ^weights;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v <= 1'b0;
          r_t <= '0;
          for (int i = 0; i < C; i++) r_p[i] <= '0;
        end else begin
          if (clear) r_v <= 1'b0;
          else if (!w_stall) r_v <= in_valid;
          if (in_valid && !w_stall) begin
            r_t <= threshold;
            for (int i = 0; i < C; i++) r_p[i] <= w_p[i];
          end
        end
      end

      assign w_q = r_p;
      assign w_v = r_v;
      assign w_t = r_t;
    end else begin : g_add
      localparam int PC = f_cnt(l-1);
      localparam int O  = PC % 2;
      localparam bit REG = (l == D) || (l % PIPE_EVERY == 0);
      logic [LW-1:0] w_s [C];

      // odd leftover passes up on node 0 so the upper half is the larger one
      for (genvar j = 0; j < C; j++) begin : g_n
        if (O == 1 && j == 0) begin : g_pass
          assign w_s[j] = LW'(g_lv[l-1].w_q[0]);
        end else begin : g_pair
          assign w_s[j] = LW'(g_lv[l-1].w_q[2*j-O])
                        + LW'(g_lv[l-1].w_q[2*j-O+1]);
        end
      end

      if (l == D) begin : g_out
        logic [SUM_W-1:0] r_s;
        logic             r_g;
        logic             r_v;

        assign w_t = g_lv[l-1].w_t;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_s <= '0;
            r_g <= 1'b0;
            r_v <= 1'b0;
          end else begin
            if (clear) r_v <= 1'b0;
            else if (!w_stall) r_v <= g_lv[l-1].w_v;
            if (!w_stall) begin
              r_s <= w_s[0];
              r_g <= (w_s[0] >= w_t);
            end
          end
        end

        assign w_q[0] = r_s;
        assign w_v    = r_v;
        assign ge     = r_g;
      end else if (REG) begin : g_reg
        logic [LW-1:0]    r_q [C];
        logic             r_v;
        logic [SUM_W-1:0] r_t;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_v <= 1'b0;
            r_t <= '0;
            for (int j = 0; j < C; j++) r_q[j] <= '0;
          end else begin
            if (clear) r_v <= 1'b0;
            else if (!w_stall) r_v <= g_lv[l-1].w_v;
            if (!w_stall) begin
              r_t <= g_lv[l-1].w_t;
              for (int j = 0; j < C; j++) r_q[j] <= w_s[j];
            end
          end
        end

        assign w_q = r_q;
        assign w_v = r_v;
        assign w_t = r_t;
      end else begin : g_comb
        assign w_q = w_s;
        assign w_v = g_lv[l-1].w_v;
        assign w_t = g_lv[l-1].w_t;
      end
    end
  end

  assign sum       = g_lv[D].w_q[0];
  assign out_valid = g_lv[D].w_v;

endmodule

// File: tb/tb_weighted_bitsum_pipe.sv
// tb_weighted_bitsum_pipe: directed and streamed checks of the weighted
// bit-sum pipeline against a behavioural sum model.
module tb_weighted_bitsum_pipe;

  localparam int N   = 9;
  localparam int WB  = 3;
  localparam int SW  = 6;
  localparam int WW  = N*WB;
  localparam int N2  = 7;
  localparam int SW2 = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [N-1:0]  in_bits = '0;
  logic [WW-1:0] weights = '0;
  logic [SW-1:0] threshold = '0;
  logic          in_ready;
  logic          out_valid;
  logic [SW-1:0] sum;
  logic          ge;

  logic           b_clear = 1'b0;
  logic           b_valid = 1'b0;
  logic           b_ready;
  logic [N2-1:0]  b_bits = '0;
  logic [N2*WB-1:0] b_w = '1;
  logic [SW2-1:0] b_thr = '0;
  logic           b_ovalid;
  logic           b_oready = 1'b1;
  logic [SW2-1:0] b_sum;
  logic           b_ge;

  int n_tot = 0;
  int n_bad = 0;
  int n_out = 0;
  logic [SW:0] q[$];

  always #5 clk = ~clk;

  weighted_bitsum_pipe #(
    .N(N), .W_BITS(WB), .WEIGHTED(1), .PIPE_EVERY(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_bits(in_bits), .weights(weights),
    .threshold(threshold), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .ge(ge)
  );

  weighted_bitsum_pipe #(
    .N(N2), .W_BITS(WB), .WEIGHTED(0), .PIPE_EVERY(1)
  ) u_pc (
    .clk(clk), .rst_n(rst_n), .clear(b_clear),
    .in_valid(b_valid), .in_ready(b_ready),
    .in_bits(b_bits), .weights(b_w),
    .threshold(b_thr), .out_valid(b_ovalid),
    .out_ready(b_oready), .sum(b_sum), .ge(b_ge)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [SW:0] model(input logic [N-1:0] b,
                                        input logic [WW-1:0] w,
                                        input logic [SW-1:0] t);
    int s;
    s = 0;
    for (int i = 0; i < N; i++)
      if (b[i]) s += int'(w[i*WB +: WB]);
    return {(s >= int'(t)), SW'(s)};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && !out_ready) begin
        chk("held_q", q.size() != 0, 1);
        if (q.size() != 0) chk("held", {ge, sum}, q[0]);
      end
      if (out_valid && out_ready) begin
        chk("out_q", q.size() != 0, 1);
        if (q.size() != 0) chk("result", {ge, sum}, q.pop_front());
        n_out++;
      end
      if (clear) q.delete();
      else if (in_valid && in_ready)
        q.push_back(model(in_bits, weights, threshold));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [N-1:0] b,
                     input logic [WW-1:0] w,
                     input logic [SW-1:0] t);
    int k;
    in_valid = 1'b1;
    in_bits = b;
    weights = w;
    threshold = t;
    k = 0;
    while (!in_ready && k < 100) begin
      tick();
      k++;
    end
    if (k == 100) chk("put_timeout", 0, 1);
    tick();
  endtask

  task automatic one(input string tag,
                     input logic [N-1:0] b,
                     input logic [WW-1:0] w,
                     input logic [SW-1:0] t,
                     input int es, input int eg);
    int k;
    put(b, w, t);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 10) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, k, 2);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_ge"}, ge, eg);
    tick();
  endtask

  logic [WW-1:0] w1, w7, wm;
  int base, sent, k;
  logic acc;

  initial begin
    w1 = '0;
    w7 = '0;
    wm = '0;
    for (int i = 0; i < N; i++) begin
      w1[i*WB +: WB] = 3'd1;
      w7[i*WB +: WB] = 3'd7;
      wm[i*WB +: WB] = 3'(i % 8);
    end

    repeat (2) tick();
    chk("rst_ov", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_ge", ge, 0);
    chk("rst_rdy", in_ready, 1);
    rst_n = 1'b1;
    tick();

    one("all1", 9'h1FF, w1, 5, 9, 1);
    one("two", 9'h011, w1, 5, 2, 0);
    one("wmod", 9'h0AA, wm, 17, 16, 0);
    one("wmodeq", 9'h0AA, wm, 16, 16, 1);
    one("max", 9'h1FF, w7, 63, 63, 1);
    one("thr0", 9'h000, w7, 0, 0, 1);
    one("near", 9'h0FF, w7, 63, 56, 0);

    base = n_out;
    for (int i = 0; i < 20; i++)
      put(N'($urandom), WW'($urandom), SW'($urandom_range(0, 63)));
    in_valid = 1'b0;
    repeat (5) tick();
    chk("stream_n", n_out - base, 20);

    base = n_out;
    sent = 0;
    in_valid = 1'b1;
    in_bits = N'($urandom);
    weights = WW'($urandom);
    threshold = SW'($urandom_range(0, 63));
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 6 && c < 10);
      #1;
      chk("bp_rdy", in_ready, (c >= 6 && c < 10) ? 0 : 1);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        sent++;
        if (sent == 12) begin
          in_valid = 1'b0;
        end else begin
          in_bits = N'($urandom);
          weights = WW'($urandom);
          threshold = SW'($urandom_range(0, 63));
        end
      end
    end
    out_ready = 1'b1;
    repeat (4) tick();
    chk("bp_n", n_out - base, 12);

    base = n_out;
    put(9'h1FF, w7, 1);
    put(9'h0F0, w7, 2);
    put(9'h00F, w7, 3);
    out_ready = 1'b0;
    in_bits = 9'h1AA;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("clr_ov", out_valid, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("clr_idle", out_valid, 0);
    end
    chk("clr_n", n_out - base, 0);

    put(9'h1FF, w7, 1);
    put(9'h0F0, w7, 2);
    put(9'h00F, w7, 3);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_ov", out_valid, 0);
    chk("mrst_sum", sum, 0);
    chk("mrst_ge", ge, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    base = n_out;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("mrst_idle", out_valid, 0);
    end
    chk("mrst_n", n_out - base, 0);

    b_valid = 1'b1;
    b_bits = 7'h7F;
    b_thr = 3'd7;
    tick();
    b_valid = 1'b0;
    k = 0;
    while (!b_ovalid && k < 10) begin
      tick();
      k++;
    end
    chk("pc_lat", k, 3);
    chk("pc_sum", b_sum, 7);
    chk("pc_ge", b_ge, 1);
    tick();
    b_valid = 1'b1;
    b_bits = 7'h15;
    b_thr = 3'd4;
    tick();
    b_valid = 1'b0;
    k = 0;
    while (!b_ovalid && k < 10) begin
      tick();
      k++;
    end
    chk("pc2_sum", b_sum, 3);
    chk("pc2_ge", b_ge, 0);
    tick();

    chk("q_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
